// File: rtl/pc_seq_if.sv
// Fetch-control bundle between the decode/branch-resolve logic (master)
// and the PC sequencer (slave).
interface pc_seq_if #(
  parameter int PC_WIDTH  = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic                       stall;
  logic                       pcsel;
  logic signed [PC_WIDTH-1:0] ain;
  logic                       jump;
  logic                       call;
  logic                       ret;
  logic        [PC_WIDTH-1:0] jtarget;
  logic        [PC_WIDTH-1:0] aout;
  logic                       halted;
  logic        [CNT_W-1:0]    ras_count;
  logic                       ras_ovf;
  logic                       ras_unf;

  modport master (
    output stall, pcsel, ain, jump, call, ret, jtarget,
    input  aout, halted, ras_count, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, pcsel, ain, jump, call, ret, jtarget,
    output aout, halted, ras_count, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: increment, relative branch, absolute jump,
// call/return through a small return-address stack, stall and end-of-program halt.
module pc_seq_unit #(
  parameter int PC_WIDTH  = 32,
  parameter int MAX_ADDR  = 255,
  parameter int RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [PC_WIDTH-1:0] aout_q, aout_d;
  logic                halted_q, halted_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PC_WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PTR_W-1:0]    wr_idx;
  logic [PTR_W-1:0]    rd_idx;
  logic                ras_empty;
  logic                ras_full;

  always_comb begin
    pc_inc    = aout_q + PC_WIDTH'(1);
    wr_idx    = PTR_W'(cnt_q);
    rd_idx    = PTR_W'(cnt_q - CNT_W'(1));
    ras_empty = (cnt_q == '0);
    ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    aout_d   = aout_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ras_d    = ras_q;

    // Reaching the last address freezes everything until reset; a halted
    // unit ignores all controls, so only the running case needs decoding.
    if (!halted_q) begin
      if (aout_q == PC_WIDTH'(MAX_ADDR)) begin
        halted_d = 1'b1;
      end else if (!bus.stall) begin
        if (bus.ret) begin
          if (!ras_empty) begin
            aout_d = ras_q[rd_idx];
            cnt_d  = cnt_q - CNT_W'(1);
          end else begin
            aout_d = pc_inc;
            unf_d  = 1'b1;
          end
        end else if (bus.call) begin
          aout_d = bus.jtarget;
          if (!ras_full) begin
            ras_d[wr_idx] = pc_inc;
            cnt_d         = cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (bus.jump) begin
          aout_d = bus.jtarget;
        end else if (bus.pcsel) begin
          aout_d = pc_inc + $unsigned(bus.ain);
        end else begin
          aout_d = pc_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      aout_q   <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      aout_q   <= aout_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Stack contents are only meaningful below cnt_q, so they need no reset.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign bus.aout      = aout_q;
  assign bus.halted    = halted_q;
  assign bus.ras_count = cnt_q;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed vector table, hand-written RAS/halt
// sequences, then randomized controls against a queue-based reference model.
module tb_pc_seq_unit;
  logic clk;
  logic reset;

  pc_seq_if #(.PC_WIDTH(32), .RAS_DEPTH(4)) bus ();

  pc_seq_unit #(.PC_WIDTH(32), .MAX_ADDR(255), .RAS_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall, pcsel, jump, call, ret;
    logic [31:0] ain, jt;
    logic [31:0] e_aout;
    logic        e_halt;
    logic [2:0]  e_cnt;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t tbl[$];
  int   n_chk;
  int   n_fail;

  // Reference model state
  bit [31:0] m_aout;
  bit        m_halt, m_ovf, m_unf;
  bit [31:0] m_ras[$];

  function automatic vec_t mk(logic r, logic s, logic p, logic j, logic c, logic rt,
                              logic [31:0] ain, logic [31:0] jt, logic [31:0] ea,
                              logic eh, logic [2:0] ec, logic eo, logic eu);
    vec_t v;
    v.rst_n = r; v.stall = s; v.pcsel = p; v.jump = j; v.call = c; v.ret = rt;
    v.ain = ain; v.jt = jt; v.e_aout = ea; v.e_halt = eh; v.e_cnt = ec;
    v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic s, logic p, logic j, logic c, logic rt,
                       logic [31:0] ain, logic [31:0] jt);
    reset       = r;
    bus.stall   = s;
    bus.pcsel   = p;
    bus.jump    = j;
    bus.call    = c;
    bus.ret     = rt;
    bus.ain     = ain;
    bus.jtarget = jt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string nm, logic [31:0] ea, logic eh, logic [2:0] ec,
                           logic eo, logic eu);
    chk({nm, ".aout"},   64'(bus.aout),      64'(ea));
    chk({nm, ".halted"}, 64'(bus.halted),    64'(eh));
    chk({nm, ".cnt"},    64'(bus.ras_count), 64'(ec));
    chk({nm, ".ovf"},    64'(bus.ras_ovf),   64'(eo));
    chk({nm, ".unf"},    64'(bus.ras_unf),   64'(eu));
  endtask

  // Reference: follows the behavioural rules directly with a queue as the stack.
  task automatic model_step(logic r, logic s, logic p, logic j, logic c, logic rt,
                            logic [31:0] ain, logic [31:0] jt);
    if (!r) begin
      m_aout = 0; m_halt = 0; m_ovf = 0; m_unf = 0; m_ras.delete();
    end else if (m_halt) begin
    end else if (m_aout == 32'd255) begin
      m_halt = 1;
    end else if (s) begin
    end else if (rt) begin
      if (m_ras.size() > 0) m_aout = m_ras.pop_back();
      else begin m_aout = m_aout + 1; m_unf = 1; end
    end else if (c) begin
      if (m_ras.size() < 4) m_ras.push_back(m_aout + 1);
      else m_ovf = 1;
      m_aout = jt;
    end else if (j) begin
      m_aout = jt;
    end else if (p) begin
      m_aout = m_aout + 1 + ain;
    end else begin
      m_aout = m_aout + 1;
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    bus.stall = 0; bus.pcsel = 0; bus.jump = 0; bus.call = 0; bus.ret = 0;
    bus.ain = '0; bus.jtarget = '0;

    //             r s p j c rt ain         jt    aout halt cnt ovf unf
    tbl.push_back(mk(0,0,0,0,0,0, 0,          0,    0,   0, 0, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,          0,    0,   0, 0, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,0, 0,          0,    1,   0, 0, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,0, 0,          0,    2,   0, 0, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,0, 0,          0,    3,   0, 0, 0, 0));
    tbl.push_back(mk(1,0,0,1,0,0, 0,          10,   10,  0, 0, 0, 0));
    tbl.push_back(mk(1,0,1,0,0,0, 5,          0,    16,  0, 0, 0, 0));
    tbl.push_back(mk(1,0,1,0,0,0, 32'hFFFF_FFFA, 0, 11,  0, 0, 0, 0));
    tbl.push_back(mk(1,0,0,1,0,0, 0,          20,   20,  0, 0, 0, 0));
    tbl.push_back(mk(1,0,0,0,1,0, 0,          100,  100, 0, 1, 0, 0));
    tbl.push_back(mk(1,0,0,0,1,0, 0,          200,  200, 0, 2, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,1, 0,          0,    101, 0, 1, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,1, 0,          0,    21,  0, 0, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,1, 0,          0,    22,  0, 0, 0, 1));
    tbl.push_back(mk(0,0,0,0,0,0, 0,          0,    0,   0, 0, 0, 0));
    tbl.push_back(mk(1,0,0,0,1,0, 0,          50,   50,  0, 1, 0, 0));
    tbl.push_back(mk(1,0,1,1,1,1, 3,          77,   1,   0, 0, 0, 0));
    tbl.push_back(mk(1,0,0,0,1,0, 0,          60,   60,  0, 1, 0, 0));
    tbl.push_back(mk(1,1,0,0,1,0, 0,          90,   60,  0, 1, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,0, 0,          0,    61,  0, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].stall, tbl[i].pcsel, tbl[i].jump, tbl[i].call,
            tbl[i].ret, tbl[i].ain, tbl[i].jt);
      check_all($sformatf("vec%0d", i), tbl[i].e_aout, tbl[i].e_halt, tbl[i].e_cnt,
                tbl[i].e_ovf, tbl[i].e_unf);
    end

    // RAS overflow then underflow
    drive(0,0,0,0,0,0, 0, 0);
    drive(1,0,0,0,1,0, 0, 30);  check_all("ras_c1", 30, 0, 1, 0, 0);
    drive(1,0,0,0,1,0, 0, 40);  check_all("ras_c2", 40, 0, 2, 0, 0);
    drive(1,0,0,0,1,0, 0, 50);  check_all("ras_c3", 50, 0, 3, 0, 0);
    drive(1,0,0,0,1,0, 0, 60);  check_all("ras_c4", 60, 0, 4, 0, 0);
    drive(1,0,0,0,1,0, 0, 70);  check_all("ras_c5", 70, 0, 4, 1, 0);
    drive(1,0,0,0,0,1, 0, 0);   check_all("ras_r1", 51, 0, 3, 1, 0);
    drive(1,0,0,0,0,1, 0, 0);   check_all("ras_r2", 41, 0, 2, 1, 0);
    drive(1,0,0,0,0,1, 0, 0);   check_all("ras_r3", 31, 0, 1, 1, 0);
    drive(1,0,0,0,0,1, 0, 0);   check_all("ras_r4", 1,  0, 0, 1, 0);
    drive(1,0,0,0,0,1, 0, 0);   check_all("ras_r5", 2,  0, 0, 1, 1);

    // Halt and recovery by reset
    drive(0,0,0,0,0,0, 0, 0);
    drive(1,0,0,0,1,0, 0, 254); check_all("halt_call", 254, 0, 1, 0, 0);
    drive(1,0,0,0,0,0, 0, 0);   check_all("halt_inc",  255, 0, 1, 0, 0);
    drive(1,0,0,1,0,0, 0, 5);   check_all("halt_set",  255, 1, 1, 0, 0);
    drive(1,0,0,0,1,0, 0, 9);   check_all("halt_call2",255, 1, 1, 0, 0);
    drive(1,0,0,0,0,1, 0, 0);   check_all("halt_ret",  255, 1, 1, 0, 0);
    drive(0,0,0,0,0,0, 0, 0);   check_all("halt_rst",  0,   0, 0, 0, 0);
    drive(1,1,0,0,0,0, 0, 0);   check_all("stall_only",0,   0, 0, 0, 0);

    // Randomized run against the reference model
    model_step(0,0,0,0,0,0, 0, 0);
    drive(0,0,0,0,0,0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      logic r, s, p, j, c, rt;
      logic [31:0] ain, jt;
      r   = ($urandom_range(0, 99) >= 3) && !(m_halt && $urandom_range(0, 3) == 0);
      s   = ($urandom_range(0, 99) < 15);
      p   = ($urandom_range(0, 99) < 30);
      j   = ($urandom_range(0, 99) < 10);
      c   = ($urandom_range(0, 99) < 20);
      rt  = ($urandom_range(0, 99) < 18);
      ain = 32'($signed($urandom_range(0, 40)) - 20);
      jt  = 32'($urandom_range(0, 258));
      model_step(r, s, p, j, c, rt, ain, jt);
      drive(r, s, p, j, c, rt, ain, jt);
      check_all($sformatf("rnd%0d", k), m_aout, m_halt, 3'(m_ras.size()), m_ovf, m_unf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
